// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, data-enable, sync strobes and frame-stable mode latch.
// Optional macro VTG_SYNC_ALIGN_EN builds the SYNC_DELAY-deep delay line behind de_d/hsync_d/vsync_d.
module video_timing_gen #(
    parameter int   H_ACTIVE   = 1280,
    parameter int   H_FP       = 110,
    parameter int   H_SYNC     = 40,
    parameter int   H_BP       = 220,
    parameter int   V_ACTIVE   = 720,
    parameter int   V_FP       = 5,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 20,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   SYNC_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [2:0]  mode_req,
    output logic [11:0] px,
    output logic [11:0] py,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        line_start,
    output logic [2:0]  mode,
    output logic        de_d,
    output logic        hsync_d,
    output logic        vsync_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    // {de, hsync, vsync} with both syncs deasserted
    localparam logic [2:0] SYNC_IDLE = {1'b0, ~HS_POL, ~VS_POL};

    if (SYNC_DELAY < 1) begin : g_bad_sync_delay
        $error("video_timing_gen: SYNC_DELAY must be at least 1");
    end

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] px_q, px_d;
    logic [11:0] py_q, py_d;
    logic [2:0]  sync_q, sync_d;
    logic        frame_start_q, frame_start_d;
    logic        line_start_q, line_start_d;
    logic [2:0]  mode_q, mode_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        px_d          = '0;
        py_d          = '0;
        sync_d        = SYNC_IDLE;
        frame_start_d = 1'b0;
        line_start_d  = 1'b0;
        mode_d        = mode_q;

        if (run) begin
            // Outputs decode the position the counters hold before this edge advances them.
            px_d          = h_cnt_q;
            py_d          = v_cnt_q;
            sync_d[2]     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            sync_d[1]     = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
            sync_d[0]     = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);

            if (frame_start_d) begin
                mode_d = mode_req;
            end

            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            px_q          <= '0;
            py_q          <= '0;
            sync_q        <= SYNC_IDLE;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            mode_q        <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            px_q          <= px_d;
            py_q          <= py_d;
            sync_q        <= sync_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            mode_q        <= mode_d;
        end
    end

    assign px          = px_q;
    assign py          = py_q;
    assign de          = sync_q[2];
    assign hsync       = sync_q[1];
    assign vsync       = sync_q[0];
    assign frame_start = frame_start_q;
    assign line_start  = line_start_q;
    assign mode        = mode_q;

`ifdef VTG_SYNC_ALIGN_EN
    logic [2:0] dly_q [SYNC_DELAY];
    logic [2:0] dly_d [SYNC_DELAY];

    always_comb begin
        dly_d[0] = sync_q;
        for (int i = 1; i < SYNC_DELAY; i++) begin
            dly_d[i] = dly_q[i-1];
        end
    end

    // NOTE: the delay line is reset stage by stage so no stale sync leaks out after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                dly_q[i] <= SYNC_IDLE;
            end
        end else begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                dly_q[i] <= dly_d[i];
            end
        end
    end

    assign {de_d, hsync_d, vsync_d} = dly_q[SYNC_DELAY-1];
`else
    assign {de_d, hsync_d, vsync_d} = sync_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a small raster and a position-from-elapsed-time model.
// Covers both builds of VTG_SYNC_ALIGN_EN.
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 3, HSW = 4, HBP = 5;
    localparam int VA = 10, VFP = 2, VSW = 3, VBP = 4;
    localparam int HT = HA + HFP + HSW + HBP;   // 28
    localparam int VT = VA + VFP + VSW + VBP;   // 19
    localparam int FRAME = HT * VT;             // 532
    localparam logic HSP = 1'b1;
    localparam logic VSP = 1'b0;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [2:0]  mode_req;
    logic [11:0] px, py;
    logic        de, hsync, vsync, frame_start, line_start;
    logic [2:0]  mode;
    logic        de_d, hsync_d, vsync_d;

    int n_checks = 0;
    int n_pass   = 0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .SYNC_DELAY(SD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode_req(mode_req),
        .px(px), .py(py), .de(de), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .line_start(line_start), .mode(mode),
        .de_d(de_d), .hsync_d(hsync_d), .vsync_d(vsync_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: position derived from clocks elapsed since run went high.
    int         t_run;
    int         m_px, m_py, m_mode;
    logic [2:0] m_sync;        // {de, hsync, vsync}
    logic [2:0] m_hist [SD];   // m_hist[k] = registered sync k+1 clocks ago
    logic [2:0] m_sync_d;
    int         m_fs, m_ls;

    always @(posedge clk) begin
        if (!rst_n) begin
            t_run = 0; m_px = 0; m_py = 0; m_mode = 0; m_fs = 0; m_ls = 0;
            m_sync = {1'b0, ~HSP, ~VSP};
            for (int k = 0; k < SD; k++) m_hist[k] = {1'b0, ~HSP, ~VSP};
        end else begin
            for (int k = SD - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_sync;
            if (!run) begin
                t_run = 0; m_px = 0; m_py = 0; m_fs = 0; m_ls = 0;
                m_sync = {1'b0, ~HSP, ~VSP};
            end else begin
                m_px = t_run % HT;
                m_py = (t_run / HT) % VT;
                m_sync[2] = (m_px < HA) && (m_py < VA);
                m_sync[1] = (m_px >= HA + HFP && m_px < HA + HFP + HSW) ? HSP : ~HSP;
                m_sync[0] = (m_py >= VA + VFP && m_py < VA + VFP + VSW) ? VSP : ~VSP;
                m_ls = (m_px == 0);
                m_fs = (m_px == 0 && m_py == 0);
                if (m_fs != 0) m_mode = int'(mode_req);
                t_run++;
            end
        end
`ifdef VTG_SYNC_ALIGN_EN
        m_sync_d = m_hist[SD-1];
`else
        m_sync_d = m_sync;
`endif
        #1;
        check("px", px, m_px);
        check("py", py, m_py);
        check("de", de, m_sync[2]);
        check("hsync", hsync, m_sync[1]);
        check("vsync", vsync, m_sync[0]);
        check("frame_start", frame_start, m_fs);
        check("line_start", line_start, m_ls);
        check("mode", mode, m_mode);
        check("de_d", de_d, m_sync_d[2]);
        check("hsync_d", hsync_d, m_sync_d[1]);
        check("vsync_d", vsync_d, m_sync_d[0]);
    end

    task automatic wait_pos(input int x, input int y);
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(negedge clk);
            if (px == 12'(x) && py == 12'(y)) found = 1;
        end
        if (!found) check("wait_pos_timeout", 0, 1);
    endtask

    task automatic wait_fs();
        bit found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            @(posedge clk); #1;
            if (frame_start) found = 1;
        end
        if (!found) check("wait_fs_timeout", 0, 1);
    endtask

    initial begin
        #(200000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_de, n_hs, n_vs, n_fs, n_ls, first_hs;
        rst_n = 1'b0; run = 1'b1; mode_req = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_px", px, 0);
        check("rst_de", de, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 1);
        check("rst_mode", mode, 0);
        check("rst_de_d", de_d, 0);
        rst_n = 1'b1;

        // First registered cycle after reset release
        @(posedge clk); #1;
        check("first_px", px, 0);
        check("first_py", py, 0);
        check("first_de", de, 1);
        check("first_fs", frame_start, 1);

        // One-frame census
        n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_ls = 0; first_hs = -1;
        for (int k = 0; k < FRAME; k++) begin
            n_de += int'(de);
            n_hs += int'(hsync == HSP);
            n_vs += int'(vsync == VSP);
            n_fs += int'(frame_start);
            n_ls += int'(line_start);
            if (hsync == HSP && first_hs < 0) first_hs = int'(px);
            @(posedge clk); #1;
        end
        check("period_fs", frame_start, 1);
        check("census_de", n_de, 160);
        check("census_hsync", n_hs, 76);
        check("census_vsync", n_vs, 84);
        check("census_fs", n_fs, 1);
        check("census_ls", n_ls, 19);
        check("first_hsync_px", first_hs, 19);

        // Mid-frame mode request is deferred to the next frame start
        wait_pos(8, 5);
        mode_req = 3'd5;
        @(posedge clk); #1;
        check("mode_hold", mode, 0);
        wait_fs();
        check("mode_new", mode, 5);

        // Request arriving on the frame-start edge itself is captured
        wait_pos(HT - 1, VT - 1);
        mode_req = 3'd3;
        @(posedge clk); #1;
        check("edge_fs", frame_start, 1);
        check("edge_mode", mode, 3);

        // Delayed de across a line boundary
        wait_pos(0, 1);
`ifdef VTG_SYNC_ALIGN_EN
        check("de_d_px0", de_d, 0);
`else
        check("de_d_px0", de_d, 1);
`endif
        wait_pos(2, 1);
        check("de_d_px2", de_d, 1);
        wait_pos(16, 1);
`ifdef VTG_SYNC_ALIGN_EN
        check("de_d_px16", de_d, 1);
`else
        check("de_d_px16", de_d, 0);
`endif

        // run drop mid-frame, hold, restart at origin
        wait_pos(10, 4);
        run = 1'b0;
        repeat (50) @(negedge clk);
        check("hold_de", de, 0);
        check("hold_px", px, 0);
        check("hold_py", py, 0);
        check("hold_hsync", hsync, 0);
        run = 1'b1;
        @(posedge clk); #1;
        check("restart_fs", frame_start, 1);
        check("restart_px", px, 0);
        check("restart_de", de, 1);

        // Randomized mode requests and run toggles
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            mode_req = 3'($urandom);
            if ($urandom_range(0, 59) == 0) run = ~run;
        end

        // Asynchronous reset mid-line clears a non-zero mode
        @(negedge clk);
        run = 1'b1; mode_req = 3'd6;
        wait_fs();
        check("pre_rst_mode", mode, 6);
        wait_pos(12, 3);
        #2 rst_n = 1'b0;
        #1;
        check("async_px", px, 0);
        check("async_py", py, 0);
        check("async_de", de, 0);
        check("async_hsync", hsync, 0);
        check("async_vsync", vsync, 1);
        check("async_mode", mode, 0);
        check("async_de_d", de_d, 0);
        check("async_vsync_d", vsync_d, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FRAME + 50) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
